// File: rtl/fp_mul.sv
// fp_mul: pipelined floating-point multiplier with flush-to-zero, canonical quiet NaN and no subnormal outputs.
// Define FP_MUL_RNE_EN for round-to-nearest-even; when it is undefined the fraction is truncated toward zero.
module fp_mul #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [I_DATA-1:0] idataA,
    input  logic [I_DATA-1:0] idataB,
    output logic [I_DATA-1:0] odata,
    output logic              out_valid
);
    localparam int PW = 2*I_MNT + 2;
    localparam int EW = I_EXP + 2;
`ifdef FP_MUL_RNE_EN
    localparam int KW = PW;
`else
    // truncation only needs the top of the product
    localparam int KW = I_MNT + 2;
`endif
    localparam logic [I_EXP-1:0]        EXP_ONES = '1;
    localparam logic signed [EW-1:0]    EXP_MAX  = {2'b00, EXP_ONES};
    localparam logic signed [EW-1:0]    BIAS     = EW'((1 << (I_EXP-1)) - 1);

    logic [I_EXP-1:0] a_exp, b_exp;
    logic [I_MNT-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_exp  = idataA[I_DATA-2:I_MNT];
    assign b_exp  = idataB[I_DATA-2:I_MNT];
    assign a_frac = idataA[I_MNT-1:0];
    assign b_frac = idataB[I_MNT-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    logic             s1_v, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [I_EXP-1:0] s1_ea, s1_eb;
    logic [I_MNT-1:0] s1_fa, s1_fb;

    logic                 s2_v, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [EW-1:0] s2_exp;
    logic [KW-1:0]        s2_prod;
    logic [PW-1:0]        mul_a, mul_b;

    assign mul_a = {{(I_MNT+1){1'b0}}, 1'b1, s1_fa};
    assign mul_b = {{(I_MNT+1){1'b0}}, 1'b1, s1_fb};

    logic                 s3_v, s3_sign, s3_nan, s3_inf, s3_zero;
    logic signed [EW-1:0] s3_exp;
    logic [I_MNT-1:0]     s3_frac;

    logic                 norm_hi;
    logic [I_MNT-1:0]     norm_frac;
    logic signed [EW-1:0] norm_exp;

    assign norm_hi   = s2_prod[KW-1];
    assign norm_frac = norm_hi ? s2_prod[KW-2 -: I_MNT] : s2_prod[KW-3 -: I_MNT];
    assign norm_exp  = s2_exp + {{(EW-1){1'b0}}, norm_hi};

    logic                 s4_v, s4_sign, s4_nan, s4_inf, s4_zero;
    logic signed [EW-1:0] s4_exp;
    logic [I_MNT-1:0]     s4_frac;
    logic [I_MNT-1:0]     rnd_frac;
    logic signed [EW-1:0] rnd_exp;

`ifdef FP_MUL_RNE_EN
    logic         s3_guard, s3_sticky;
    logic         norm_guard, norm_sticky, round_up;
    logic [I_MNT:0] frac_sum;

    assign norm_guard  = norm_hi ? s2_prod[I_MNT] : s2_prod[I_MNT-1];
    assign norm_sticky = norm_hi ? (|s2_prod[I_MNT-1:0]) : (|s2_prod[I_MNT-2:0]);
    assign round_up    = s3_guard && (s3_sticky || s3_frac[0]);
    assign frac_sum    = {1'b0, s3_frac} + {{I_MNT{1'b0}}, round_up};
    // carry-out means the significand rolled over to 2.0: fraction is already zero
    assign rnd_frac    = frac_sum[I_MNT-1:0];
    assign rnd_exp     = s3_exp + {{(EW-1){1'b0}}, frac_sum[I_MNT]};
`else
    assign rnd_frac    = s3_frac;
    assign rnd_exp     = s3_exp;
`endif

    logic exp_ovf, exp_unf;

    assign exp_ovf = !s4_exp[EW-1] && (s4_exp >= EXP_MAX);
    assign exp_unf = s4_exp[EW-1] || (s4_exp == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v <= 1'b0; s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_zero <= 1'b0;
            s1_ea <= '0; s1_eb <= '0; s1_fa <= '0; s1_fb <= '0;
            s2_v <= 1'b0; s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0; s2_zero <= 1'b0;
            s2_exp <= '0; s2_prod <= '0;
            s3_v <= 1'b0; s3_sign <= 1'b0; s3_nan <= 1'b0; s3_inf <= 1'b0; s3_zero <= 1'b0;
            s3_exp <= '0; s3_frac <= '0;
`ifdef FP_MUL_RNE_EN
            s3_guard <= 1'b0; s3_sticky <= 1'b0;
`endif
            s4_v <= 1'b0; s4_sign <= 1'b0; s4_nan <= 1'b0; s4_inf <= 1'b0; s4_zero <= 1'b0;
            s4_exp <= '0; s4_frac <= '0;
            odata <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_v    <= enable;
            s1_sign <= idataA[I_DATA-1] ^ idataB[I_DATA-1];
            s1_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            s1_inf  <= a_inf || b_inf;
            s1_zero <= a_zero || b_zero;
            s1_ea   <= a_exp;
            s1_eb   <= b_exp;
            s1_fa   <= a_frac;
            s1_fb   <= b_frac;

            s2_v    <= s1_v;
            s2_sign <= s1_sign;
            s2_nan  <= s1_nan;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_exp  <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;
            s2_prod <= KW'((mul_a * mul_b) >> (PW - KW));

            s3_v    <= s2_v;
            s3_sign <= s2_sign;
            s3_nan  <= s2_nan;
            s3_inf  <= s2_inf;
            s3_zero <= s2_zero;
            s3_exp  <= norm_exp;
            s3_frac <= norm_frac;
`ifdef FP_MUL_RNE_EN
            s3_guard  <= norm_guard;
            s3_sticky <= norm_sticky;
`endif

            s4_v    <= s3_v;
            s4_sign <= s3_sign;
            s4_nan  <= s3_nan;
            s4_inf  <= s3_inf;
            s4_zero <= s3_zero;
            s4_exp  <= rnd_exp;
            s4_frac <= rnd_frac;

            out_valid <= s4_v;
            if (s4_nan)
                odata <= {1'b0, EXP_ONES, 1'b1, {(I_MNT-1){1'b0}}};
            else if (s4_inf)
                odata <= {s4_sign, EXP_ONES, {I_MNT{1'b0}}};
            else if (s4_zero)
                odata <= {s4_sign, {(I_DATA-1){1'b0}}};
            else if (exp_ovf)
                odata <= {s4_sign, EXP_ONES, {I_MNT{1'b0}}};
            else if (exp_unf)
                odata <= {s4_sign, {(I_DATA-1){1'b0}}};
            else
                odata <= {s4_sign, s4_exp[I_EXP-1:0], s4_frac};
        end
    end
endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: random and directed products for single- and half-precision fp_mul instances,
// checked against an arithmetic reference model.
module tb_fp_mul;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] sp_a, sp_b, sp_out;
    logic [15:0] hp_a, hp_b, hp_out;
    logic        sp_valid, hp_valid;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    fp_mul u_sp (
        .clk(clk), .reset(reset), .enable(enable),
        .idataA(sp_a), .idataB(sp_b), .odata(sp_out), .out_valid(sp_valid)
    );

    fp_mul #(.I_EXP(5), .I_MNT(10)) u_hp (
        .clk(clk), .reset(reset), .enable(enable),
        .idataA(hp_a), .idataB(hp_b), .odata(hp_out), .out_valid(hp_valid)
    );

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] TIE_EXP = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_EXP = 32'h3FC00001;
`endif

    logic [31:0] dir_sp [7][3];
    logic [15:0] dir_hp [7][3];

    typedef struct {
        logic        v;
        logic [31:0] sp;
        logic [15:0] hp;
        string       tag;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // value of a normal operand is (1.f) * 2^(e-bias); product rounded by comparing the
    // discarded remainder against one half ulp
    function automatic logic [31:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
        longint one, ones, bias, fmask, ua, ub, ea, eb, fa, fb, s, p, e, sh, q_m, r, half;
        bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [31:0] zw, iw;
        one   = 1;
        ones  = (one << ew) - 1;
        bias  = (one << (ew - 1)) - 1;
        fmask = (one << mw) - 1;
        ua = {32'b0, a};
        ub = {32'b0, b};
        ea = (ua >> mw) & ones;
        eb = (ub >> mw) & ones;
        fa = ua & fmask;
        fb = ub & fmask;
        s  = ((ua >> (ew + mw)) ^ (ub >> (ew + mw))) & 1;
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == ones) && (fa == 0);
        b_inf  = (eb == ones) && (fb == 0);
        a_nan  = (ea == ones) && (fa != 0);
        b_nan  = (eb == ones) && (fb != 0);
        zw = 32'(s << (ew + mw));
        iw = zw | 32'(ones << mw);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            return 32'((ones << mw) | (one << (mw - 1)));
        if (a_inf || b_inf) return iw;
        if (a_zero || b_zero) return zw;
        p  = ((one << mw) | fa) * ((one << mw) | fb);
        e  = ea + eb - bias;
        sh = mw;
        if (p >= (one << (2*mw + 1))) begin
            sh = mw + 1;
            e  = e + 1;
        end
        q_m  = p >> sh;
        r    = p - (q_m << sh);
        half = one << (sh - 1);
`ifdef FP_MUL_RNE_EN
        if (r > half || (r == half && (q_m & 1) == 1)) q_m = q_m + 1;
        if (q_m == (one << (mw + 1))) begin
            q_m = q_m >> 1;
            e   = e + 1;
        end
`else
        if (r > half) q_m = q_m + 0;
`endif
        if (e >= ones) return iw;
        if (e <= 0) return zw;
        return zw | 32'(e << mw) | 32'(q_m & fmask);
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        int          ones, bias, spread, sel, e;
        logic [31:0] f, sgn;
        ones   = (1 << ew) - 1;
        bias   = (1 << (ew - 1)) - 1;
        spread = (ew == 8) ? 20 : 6;
        sel    = int'($urandom_range(0, 15));
        f      = $urandom & ((32'h1 << mw) - 1);
        sgn    = {31'b0, 1'($urandom)};
        if (sel == 0) e = 0;
        else if (sel == 1) begin e = ones; f = 0; end
        else if (sel == 2) begin e = ones; f = f | 32'h1; end
        else if (sel <= 5) e = int'($urandom_range(1, ones - 1));
        else e = int'($urandom_range(bias - spread, bias + spread));
        return (sgn << (ew + mw)) | (32'(e) << mw) | f;
    endfunction

    task automatic step(input string tag, input logic en,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] want_sp, input logic [15:0] want_hp);
        exp_t e;
        enable = en;
        sp_a = a;
        sp_b = b;
        hp_a = x;
        hp_b = y;
        e.v = en;
        e.sp = want_sp;
        e.hp = want_hp;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 5) begin
            e = q.pop_front();
            check({e.tag, "_sp_valid"}, {31'b0, sp_valid}, {31'b0, e.v});
            check({e.tag, "_hp_valid"}, {31'b0, hp_valid}, {31'b0, e.v});
            if (e.v) begin
                check({e.tag, "_sp_data"}, sp_out, e.sp);
                check({e.tag, "_hp_data"}, {16'b0, hp_out}, {16'b0, e.hp});
            end
        end else begin
            check({tag, "_sp_idle"}, {31'b0, sp_valid}, 32'd0);
            check({tag, "_hp_idle"}, {31'b0, hp_valid}, 32'd0);
        end
    endtask

    task automatic run(input string tag, input logic en,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] x, input logic [15:0] y);
        logic [31:0] ms, mh;
        ms = ref_mul(8, 23, a, b);
        mh = ref_mul(5, 10, {16'b0, x}, {16'b0, y});
        step(tag, en, a, b, x, y, ms, mh[15:0]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sp_valid"}, {31'b0, sp_valid}, 32'd0);
        check({tag, "_sp_data"}, sp_out, 32'd0);
        check({tag, "_hp_valid"}, {31'b0, hp_valid}, 32'd0);
        check({tag, "_hp_data"}, {16'b0, hp_out}, 32'd0);
    endtask

    initial begin
        dir_sp = '{'{32'h3FC00000, 32'h3FC00000, 32'h40100000},
                   '{32'h40000000, 32'hC0400000, 32'hC0C00000},
                   '{32'h3FC00000, 32'h3F800001, TIE_EXP},
                   '{32'h7F800000, 32'h00000000, 32'h7FC00000},
                   '{32'h7F000000, 32'h7F000000, 32'h7F800000},
                   '{32'h00800000, 32'h00800000, 32'h00000000},
                   '{32'h80000000, 32'h3F800000, 32'h80000000}};
        dir_hp = '{'{16'h3E00, 16'h3E00, 16'h4080},
                   '{16'h7BFF, 16'h4000, 16'h7C00},
                   '{16'h3C00, 16'h3C00, 16'h3C00},
                   '{16'hFC00, 16'h0000, 16'h7E00},
                   '{16'h7E01, 16'h3C00, 16'h7E00},
                   '{16'h0400, 16'h0400, 16'h0000},
                   '{16'hC000, 16'h4200, 16'hC600}};
        reset = 1'b1;
        enable = 1'b0;
        sp_a = '0; sp_b = '0; hp_a = '0; hp_b = '0;
        #1 reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset("rst");
        end
        q.delete();
        reset = 1'b1;

        repeat (6) run("sq", 1'b1, 32'h3F3759DF, 32'h3F3759DF, 16'h3E00, 16'h3E00);

        for (int i = 0; i < 7; i++)
            step($sformatf("dir%0d", i), 1'b1, dir_sp[i][0], dir_sp[i][1],
                 dir_hp[i][0], dir_hp[i][1], dir_sp[i][2], dir_hp[i][2]);

        for (int i = 0; i < 10; i++)
            run($sformatf("tog%0d", i), (i % 2) == 0, rand_op(8, 23), rand_op(8, 23),
                16'(rand_op(5, 10)), 16'(rand_op(5, 10)));

        for (int i = 0; i < 300; i++)
            run("rnd", $urandom_range(0, 3) != 0, rand_op(8, 23), rand_op(8, 23),
                16'(rand_op(5, 10)), 16'(rand_op(5, 10)));

        repeat (3) run("inflight", 1'b1, rand_op(8, 23), rand_op(8, 23),
                       16'(rand_op(5, 10)), 16'(rand_op(5, 10)));
        reset = 1'b0;
        #1;
        check_reset("async_rst");
        q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset("hold_rst");
        end
        reset = 1'b1;
        repeat (8) run("post_rst", 1'b0, rand_op(8, 23), rand_op(8, 23),
                       16'(rand_op(5, 10)), 16'(rand_op(5, 10)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_mul.md
# fp_mul

Parameterized IEEE-754-style floating-point multiplier. It is fully pipelined and accepts one operand pair per clock. It is used as the arithmetic primitive in the MIMO-OFDM datapath, in single precision (8/23) and half precision (5/10). It implements flush-to-zero for subnormals, special-value handling, and round-to-nearest-even.

## Interface
- I_EXP, 8, exponent field width (5 for half precision).
- I_MNT, 23, stored mantissa (fraction) width (10 for half precision).
- I_DATA, I_EXP+I_MNT+1, total word width; layout {sign, exponent, fraction}.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state.
- enable  input  1  input-valid qualifier for idataA/idataB in the current cycle.
- idataA  input  I_DATA  operand A.
- idataB  input  I_DATA  operand B.
- odata  output  I_DATA  registered product.
- out_valid  output  1  odata holds the result of an enabled input pair.

## Operation
- **Bias.** Bias = 2^(I_EXP-1)-1.
- **Operand classification.**
  - exp==0 is treated as zero; the fraction is ignored (subnormal inputs flush to signed zero).
  - exp==all-ones with fraction==0 is Inf.
  - exp==all-ones with fraction!=0 is NaN.
- **Sign.** sign = signA XOR signB for all non-NaN results.
- **Special cases (priority order).**
  - Any NaN operand, or Inf×0, gives the canonical quiet NaN {0, all-ones, 1, zeros}.
  - Otherwise, either operand Inf gives signed Inf.
  - Otherwise, either operand zero gives signed zero.
- **Normal path.**
  - Significands {1,fracA} × {1,fracB} form a (2·I_MNT+2)-bit product.
  - If product MSB=1, shift right by 1 and increment the exponent.
  - Exponent arithmetic is signed, I_EXP+2 bits wide: eA+eB−bias(+1).
- **Rounding.** Round-to-nearest-even using guard bit plus sticky (OR of all lower bits). A mantissa carry-out from rounding renormalizes and increments the exponent.
- **Range limits.**
  - Final exponent ≥ all-ones gives signed Inf (no saturation to max-finite).
  - Final exponent ≤ 0 gives signed zero (no subnormal outputs).
- **enable.** enable does not stall the pipeline; data advances every cycle. enable only rides alongside as a valid bit.

## Timing
- Four register stages; latency is exactly 4 cycles from a sampling edge to odata/out_valid.
  - S1: register and unpack operands, classify.
  - S2: significand multiply, exponent add.
  - S3: normalize, round.
  - S4: overflow/underflow/special select, pack.
- Throughput is one result per cycle.
- An input pair sampled at edge N with enable=1 produces out_valid=1 and the result after edge N+4.
- When enable=0, out_valid=0 four cycles later; odata is still updated from whatever the inputs were (don't-care, not held).
- **Reset.** Asynchronous assert: odata=0 and out_valid=0 immediately, and all pipeline valid bits are cleared.
  - Deassertion is synchronous to clk (externally synchronized).
  - Results in flight when reset asserts are discarded; none emerge afterward.
  - The first valid output occurs no earlier than 4 edges after the first enabled post-reset sample.
- Back-to-back enabled inputs produce consecutive out_valid cycles in input order.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even as described above.
- FP_MUL_RNE_EN undefined: the rounding logic is removed and the fraction is truncated toward zero.
  - Latency stays 4 cycles.
  - Special, overflow and underflow handling are unchanged.

## Test plan
- Reset and latency: hold reset=0 for 3 cycles, then release with enable=1 and A=B=0x3F3759DF held.
  - out_valid=0 and odata=0 during reset.
  - out_valid rises exactly 4 edges after the first enabled sample.
  - odata equals the IEEE RNE square of 0x3F3759DF.
- Basic products in single precision:
  - 0x3FC00000×0x3FC00000 gives 0x40100000.
  - 0x40000000×0xC0400000 gives 0xC0C00000.
- Rounding tie: 0x3FC00000×0x3F800001 gives 0x3FC00002 with FP_MUL_RNE_EN, and 0x3FC00001 without.
- Specials:
  - 0x7F800000×0x00000000 gives 0x7FC00000.
  - 0x7F000000×0x7F000000 gives 0x7F800000.
  - 0x00800000×0x00800000 gives 0x00000000.
  - 0x80000000×0x3F800000 gives 0x80000000.
- Pipelining and enable: stream 10 distinct pairs with enable toggling 1,0,1,…
  - out_valid reproduces the enable pattern delayed by 4 cycles.
  - Each valid odata matches its own input pair.
- Half precision (I_EXP=5, I_MNT=10):
  - 0x3E00×0x3E00 gives 0x4080.
  - 0x7BFF×0x4000 gives 0x7C00.
- Mid-stream reset assertion with 3 results in flight: no out_valid pulses appear after reset.
